icache: RTL

Direct-mapped, read-only instruction cache between the datapath's instruction fetch port and the memory controller's instruction port. It hits combinationally for cached words. On a miss it runs a fetch FSM to the memory controller, fills the frame, and bypasses the fill data straight to the datapath. One 32-bit word per block; no write path, because instruction memory is never written through this block.

---
 rtl/icache.sv | 117 +++++++++++
 1 files changed

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with one 32-bit word per frame.
// Hits are combinational; a miss runs a single-state fetch to the memory
// controller, fills the frame and bypasses the returned word to the datapath.
module icache #(
    parameter int unsigned SETS = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
);

    localparam int unsigned IW = $clog2(SETS);
    localparam int unsigned TW = 30 - IW;

    typedef enum logic [0:0] {
        StIdle,
        StFetch
    } state_e;

    state_e state_q, state_d;

    // Frame storage: valid bits are reset; tag and data are not
    logic [SETS-1:0] valid_q, valid_d;
    logic [TW-1:0]   tag_q  [SETS];
    logic [TW-1:0]   tag_d  [SETS];
    logic [31:0]     data_q [SETS];
    logic [31:0]     data_d [SETS];

    logic [IW-1:0] idx;
    logic [TW-1:0] tag;
    logic          hit_raw;
    logic          fill;

    // Byte-offset bits never participate in a word-aligned fetch
    logic unused_addr_bits;
    assign unused_addr_bits = ^imemaddr[1:0];

    assign idx     = imemaddr[IW+1:2];
    assign tag     = imemaddr[31:IW+2];
    assign hit_raw = valid_q[idx] && (tag_q[idx] == tag);
    assign iaddr   = {imemaddr[31:2], 2'b00};

    // Fetch FSM next state and all datapath/memory-side outputs
    always_comb begin
        state_d  = state_q;
        ihit     = 1'b0;
        iREN     = 1'b0;
        imemload = data_q[idx];
        fill     = 1'b0;
        case (state_q)
            StIdle: begin
                if (imemREN && hit_raw) begin
                    ihit = 1'b1;
                end else if (imemREN) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                iREN = 1'b1;
                if (!imemREN) begin
                    // Datapath withdrew the request: abandon without filling
                    state_d = StIdle;
                end else if (!iwait) begin
                    fill     = 1'b1;
                    ihit     = 1'b1;
                    imemload = iload;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        // During reset the outputs look like IDLE with every frame invalid
        if (!nRST) begin
            ihit    = 1'b0;
            iREN    = 1'b0;
            fill    = 1'b0;
            state_d = StIdle;
        end
    end

    // Frame next state: a fill overwrites the indexed frame unconditionally
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (fill) begin
            valid_d[idx] = 1'b1;
            tag_d[idx]   = tag;
            data_d[idx]  = iload;
        end
    end

    // State and valid bits with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= StIdle;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
        end
    end

    // Tag and data arrays carry no reset; valid gates their use
    always_ff @(posedge CLK) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

endmodule
